// File: rtl/intc_pkg.sv
// ----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller arbiter:
//   - intc_state_t : request/service FSM states
//   - RST_STATE / RST_BIT : values every register takes on reset
//   - intc_vec_w() : width of a line index for a given number of lines
// ----------------------------------------------------------------------------
package intc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ_INT = 2'd1,
        REQ_NMI = 2'd2,
        SERVICE = 2'd3
    } intc_state_t;

    localparam intc_state_t RST_STATE = IDLE;
    localparam logic        RST_BIT   = 1'b0;

    // Index width for n lines; never below one bit so a single line still has a port.
    function automatic int intc_vec_w(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// ----------------------------------------------------------------------------
// intc_prio_enc
// Combinational find-first-set over the eligible request vector. The search
// begins at index 'base' and wraps around, so base = 0 gives fixed priority
// with index 0 highest.
// Ports:
//   eligible [N_IRQ] in  : candidate request bits
//   base     [VEC_W] in  : first index examined
//   found           out  : at least one eligible bit exists
//   id       [VEC_W] out : index of the first eligible bit at or after base
// ----------------------------------------------------------------------------
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int VEC_W = intc_vec_w(N_IRQ)
) (
    input  logic [N_IRQ-1:0] eligible,
    input  logic [VEC_W-1:0] base,
    output logic             found,
    output logic [VEC_W-1:0] id
);

    int               sum_v;
    logic [VEC_W-1:0] idx_v;

    // Walk the lines from base upward with wrap-around; the first hit is the winner.
    always_comb begin
        found = 1'b0;
        id    = '0;
        sum_v = 32'sd0;
        idx_v = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            sum_v = int'(base) + i;
            idx_v = (sum_v >= N_IRQ) ? VEC_W'(sum_v - N_IRQ) : VEC_W'(sum_v);
            if (!found && eligible[idx_v]) begin
                found = 1'b1;
                id    = idx_v;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/intc_arbiter.sv
// ----------------------------------------------------------------------------
// intc_arbiter
// Interrupt controller in front of the cpu. Captures rising edges on the
// maskable request lines and the NMI source, masks and prioritises them,
// raises INT / NMI towards the cpu, and on INA presents the winning vector.
// Further requests are held off until software pulses eoi.
//
// Build option: define INTC_ROTATE_PRIO_EN for rotating priority (search
// starts after the most recently acknowledged line). Without it, priority is
// fixed with line 0 highest.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   irq[N_IRQ]         maskable requests, rising-edge triggered
//   nmi_src            non-maskable request, rising-edge triggered
//   mask_we/mask_wdata mask register write (1 = line masked)
//   gdis               software global disable of maskable interrupts
//   eoi                end-of-interrupt pulse
//   INA                acknowledge pulse from the cpu
//   INT, NMI           requests to the cpu (registered)
//   INT_Disable        gdis | in-service (registered)
//   irq_vec            id of last acknowledged maskable line
//   irq_is_nmi         last acknowledge was the NMI
//   vec_valid          one-cycle pulse after an accepted acknowledge
//   pending, mask      latched request bits and mask register
// ----------------------------------------------------------------------------
module intc_arbiter
    import intc_pkg::*;
#(
    parameter int N_IRQ = 8,
    parameter int VEC_W = intc_vec_w(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic             nmi_src,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             gdis,
    input  logic             eoi,
    input  logic             INA,
    output logic             INT,
    output logic             NMI,
    output logic             INT_Disable,
    output logic [VEC_W-1:0] irq_vec,
    output logic             irq_is_nmi,
    output logic             vec_valid,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask
);

    intc_state_t      state_r;
    intc_state_t      state_nxt_s;
    logic [N_IRQ-1:0] irq_q_r;
    logic [N_IRQ-1:0] pending_r;
    logic [N_IRQ-1:0] mask_r;
    logic             nmi_q_r;
    logic             nmi_pend_r;
    logic [VEC_W-1:0] cur_id_r;
    logic [VEC_W-1:0] cur_id_nxt_s;

    logic [N_IRQ-1:0] eligible_s;
    logic [N_IRQ-1:0] pend_set_s;
    logic [N_IRQ-1:0] pend_clr_s;
    logic             nmi_set_s;
    logic             win_found_s;
    logic [VEC_W-1:0] win_id_s;
    logic [VEC_W-1:0] base_s;
    logic             ack_int_s;
    logic             ack_nmi_s;

    assign eligible_s = pending_r & ~mask_r;
    assign pend_set_s = irq & ~irq_q_r;
    assign nmi_set_s  = nmi_src & ~nmi_q_r;
    assign pending    = pending_r;
    assign mask       = mask_r;

`ifdef INTC_ROTATE_PRIO_EN
    logic [VEC_W-1:0] rot_ptr_r;

    // Rotation pointer: move past the line that was just acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rot_ptr_r <= '0;
        end else if (ack_int_s) begin
            rot_ptr_r <= (cur_id_r == VEC_W'(N_IRQ - 1)) ? '0 : cur_id_r + VEC_W'(1);
        end else begin
            rot_ptr_r <= rot_ptr_r;
        end
    end

    assign base_s = rot_ptr_r;
`else
    assign base_s = '0;
`endif

    intc_prio_enc #(
        .N_IRQ (N_IRQ),
        .VEC_W (VEC_W)
    ) u_prio_enc (
        .eligible (eligible_s),
        .base     (base_s),
        .found    (win_found_s),
        .id       (win_id_s)
    );

    // Next-state logic; NMI pre-empts a maskable request that is still waiting for INA.
    always_comb begin
        state_nxt_s  = state_r;
        cur_id_nxt_s = cur_id_r;
        ack_int_s    = 1'b0;
        ack_nmi_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (nmi_pend_r) begin
                    state_nxt_s = REQ_NMI;
                end else if (win_found_s && !gdis) begin
                    state_nxt_s  = REQ_INT;
                    cur_id_nxt_s = win_id_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ_INT: begin
                if (nmi_pend_r) begin
                    state_nxt_s = REQ_NMI;
                end else if (gdis || !eligible_s[cur_id_r]) begin
                    // Request vanished (masked or globally disabled) before the cpu took it.
                    state_nxt_s = IDLE;
                end else if (INA) begin
                    ack_int_s   = 1'b1;
                    state_nxt_s = SERVICE;
                end else begin
                    state_nxt_s = REQ_INT;
                end
            end
            REQ_NMI: begin
                if (INA) begin
                    ack_nmi_s   = 1'b1;
                    state_nxt_s = SERVICE;
                end else begin
                    state_nxt_s = REQ_NMI;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SERVICE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // One-hot clear of the line being acknowledged.
    always_comb begin
        pend_clr_s = '0;
        if (ack_int_s) begin
            pend_clr_s[cur_id_r] = 1'b1;
        end else begin
            pend_clr_s = '0;
        end
    end

    // Core state: FSM, edge-detect history, pending bits (set beats clear), mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RST_STATE;
            cur_id_r   <= '0;
            irq_q_r    <= '0;
            nmi_q_r    <= RST_BIT;
            pending_r  <= '0;
            nmi_pend_r <= RST_BIT;
            mask_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            cur_id_r   <= cur_id_nxt_s;
            irq_q_r    <= irq;
            nmi_q_r    <= nmi_src;
            pending_r  <= (pending_r & ~pend_clr_s) | pend_set_s;
            nmi_pend_r <= (nmi_pend_r & ~ack_nmi_s) | nmi_set_s;
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
        end
    end

    // Cpu-facing outputs, registered from the current state and acknowledge decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            INT         <= RST_BIT;
            NMI         <= RST_BIT;
            INT_Disable <= RST_BIT;
            vec_valid   <= RST_BIT;
            irq_is_nmi  <= RST_BIT;
            irq_vec     <= '0;
        end else begin
            INT         <= (state_r == REQ_INT);
            NMI         <= (state_r == REQ_NMI);
            INT_Disable <= gdis | (state_r == SERVICE);
            vec_valid   <= ack_int_s | ack_nmi_s;
            if (ack_int_s) begin
                irq_vec    <= cur_id_r;
                irq_is_nmi <= 1'b0;
            end else if (ack_nmi_s) begin
                // irq_vec keeps the last maskable id; irq_is_nmi marks this ack.
                irq_is_nmi <= 1'b1;
            end else begin
                irq_is_nmi <= irq_is_nmi;
            end
        end
    end

endmodule

// File: tb/tb_intc_arbiter.sv
// ----------------------------------------------------------------------------
// tb_intc_arbiter
// Directed testbench for intc_arbiter: reset, single request, priority order,
// masking, NMI pre-emption and global disable, asynchronous reset in service.
// Honours INTC_ROTATE_PRIO_EN for the rotating-priority expectations.
// ----------------------------------------------------------------------------
module tb_intc_arbiter;

    localparam int N_IRQ = 8;
    localparam int VEC_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IRQ-1:0] irq;
    logic             nmi_src;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             gdis;
    logic             eoi;
    logic             INA;
    logic             INT;
    logic             NMI;
    logic             INT_Disable;
    logic [VEC_W-1:0] irq_vec;
    logic             irq_is_nmi;
    logic             vec_valid;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;

    int n_cmp = 0;
    int n_bad = 0;

    intc_arbiter #(.N_IRQ(N_IRQ), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst_n(rst_n), .irq(irq), .nmi_src(nmi_src),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .gdis(gdis), .eoi(eoi),
        .INA(INA), .INT(INT), .NMI(NMI), .INT_Disable(INT_Disable),
        .irq_vec(irq_vec), .irq_is_nmi(irq_is_nmi), .vec_valid(vec_valid),
        .pending(pending), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_int(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (INT === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_nmi(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (NMI === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_ina();
        INA = 1'b1;
        tick();
        INA = 1'b0;
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; irq = '0; nmi_src = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        gdis = 1'b0; eoi = 1'b0; INA = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; irq = '0; nmi_src = 1'b0; mask_we = 1'b0; mask_wdata = '0;
        gdis = 1'b0; eoi = 1'b0; INA = 1'b0;
        tick();
        tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL rst_int: got %b want 0", INT); end
        n_cmp++; if (NMI !== 1'b0) begin n_bad++; $display("FAIL rst_nmi: got %b want 0", NMI); end
        n_cmp++; if (INT_Disable !== 1'b0) begin n_bad++; $display("FAIL rst_intdis: got %b want 0", INT_Disable); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rst_pending: got %h want 00", pending); end
        n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL rst_mask: got %h want 00", mask); end
        n_cmp++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL rst_vvalid: got %b want 0", vec_valid); end
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL rst_idle_int: got %b want 0", INT); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rst_idle_pending: got %h want 00", pending); end
    endtask

    task automatic test_single();
        irq = 8'h08;
        tick();
        n_cmp++; if (pending !== 8'h08) begin n_bad++; $display("FAIL single_pend: got %h want 08", pending); end
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL single_int_t0: got %b want 0", INT); end
        tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL single_int_t1: got %b want 0", INT); end
        tick();
        n_cmp++; if (INT !== 1'b1) begin n_bad++; $display("FAIL single_int_t2: got %b want 1", INT); end
        pulse_ina();
        n_cmp++; if (vec_valid !== 1'b1) begin n_bad++; $display("FAIL single_vvalid: got %b want 1", vec_valid); end
        n_cmp++; if (irq_vec !== 3'd3) begin n_bad++; $display("FAIL single_vec: got %0d want 3", irq_vec); end
        n_cmp++; if (irq_is_nmi !== 1'b0) begin n_bad++; $display("FAIL single_isnmi: got %b want 0", irq_is_nmi); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL single_pend_clr: got %h want 00", pending); end
        tick();
        n_cmp++; if (vec_valid !== 1'b0) begin n_bad++; $display("FAIL single_vvalid_drop: got %b want 0", vec_valid); end
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL single_int_drop: got %b want 0", INT); end
        n_cmp++; if (INT_Disable !== 1'b1) begin n_bad++; $display("FAIL single_intdis: got %b want 1", INT_Disable); end
        tick(); tick();
        n_cmp++; if (INT_Disable !== 1'b1) begin n_bad++; $display("FAIL single_intdis_hold: got %b want 1", INT_Disable); end
        pulse_eoi();
        tick();
        n_cmp++; if (INT_Disable !== 1'b0) begin n_bad++; $display("FAIL single_intdis_eoi: got %b want 0", INT_Disable); end
        irq = 8'h00;
        tick();
    endtask

    task automatic test_priority();
        bit ok;
        logic [VEC_W-1:0] exp_b2;
        logic [VEC_W-1:0] exp_b3;
`ifdef INTC_ROTATE_PRIO_EN
        exp_b2 = 3'd5; exp_b3 = 3'd2;
`else
        exp_b2 = 3'd2; exp_b3 = 3'd5;
`endif
        apply_reset();
        // Phase A: two lines together, lower index first, then the other after eoi.
        irq = 8'h24;
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL prio_a1_wait: got %b want 1", ok); end
        n_cmp++; if (pending !== 8'h24) begin n_bad++; $display("FAIL prio_a_pend: got %h want 24", pending); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd2) begin n_bad++; $display("FAIL prio_a1_vec: got %0d want 2", irq_vec); end
        n_cmp++; if (pending !== 8'h20) begin n_bad++; $display("FAIL prio_a1_pend: got %h want 20", pending); end
        tick();
        pulse_eoi();
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL prio_a2_wait: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd5) begin n_bad++; $display("FAIL prio_a2_vec: got %0d want 5", irq_vec); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL prio_a2_pend: got %h want 00", pending); end
        tick();
        pulse_eoi();
        irq = 8'h00;
        tick();
        // Phase B: serve 2, re-raise 2 during service, then both pending again.
        irq = 8'h24;
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL prio_b1_wait: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd2) begin n_bad++; $display("FAIL prio_b1_vec: got %0d want 2", irq_vec); end
        tick();
        irq = 8'h20;
        tick();
        irq = 8'h24;
        tick();
        n_cmp++; if (pending !== 8'h24) begin n_bad++; $display("FAIL prio_b_repend: got %h want 24", pending); end
        pulse_eoi();
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL prio_b2_wait: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== exp_b2) begin n_bad++; $display("FAIL prio_b2_vec: got %0d want %0d", irq_vec, exp_b2); end
        tick();
        pulse_eoi();
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL prio_b3_wait: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== exp_b3) begin n_bad++; $display("FAIL prio_b3_vec: got %0d want %0d", irq_vec, exp_b3); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL prio_b3_pend: got %h want 00", pending); end
        tick();
        pulse_eoi();
        irq = 8'h00;
        tick();
    endtask

    task automatic test_mask();
        mask_we = 1'b1; mask_wdata = 8'h04;
        tick();
        mask_we = 1'b0;
        n_cmp++; if (mask !== 8'h04) begin n_bad++; $display("FAIL mask_reg: got %h want 04", mask); end
        irq = 8'h04;
        tick();
        n_cmp++; if (pending !== 8'h04) begin n_bad++; $display("FAIL mask_pend: got %h want 04", pending); end
        tick(); tick(); tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL mask_int_blocked: got %b want 0", INT); end
        n_cmp++; if (pending !== 8'h04) begin n_bad++; $display("FAIL mask_pend_hold: got %h want 04", pending); end
        mask_we = 1'b1; mask_wdata = 8'h00;
        tick();
        mask_we = 1'b0;
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL mask_unmask_t0: got %b want 0", INT); end
        tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL mask_unmask_t1: got %b want 0", INT); end
        tick();
        n_cmp++; if (INT !== 1'b1) begin n_bad++; $display("FAIL mask_unmask_t2: got %b want 1", INT); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd2) begin n_bad++; $display("FAIL mask_vec: got %0d want 2", irq_vec); end
        tick();
        pulse_eoi();
        irq = 8'h00;
        tick();
    endtask

    task automatic test_nmi();
        bit ok;
        // NMI arriving while a maskable request is waiting for INA.
        irq = 8'h02;
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL nmi_int_wait: got %b want 1", ok); end
        nmi_src = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL nmi_int_retract: got %b want 0", INT); end
        n_cmp++; if (NMI !== 1'b1) begin n_bad++; $display("FAIL nmi_raise: got %b want 1", NMI); end
        pulse_ina();
        n_cmp++; if (vec_valid !== 1'b1) begin n_bad++; $display("FAIL nmi_vvalid: got %b want 1", vec_valid); end
        n_cmp++; if (irq_is_nmi !== 1'b1) begin n_bad++; $display("FAIL nmi_isnmi: got %b want 1", irq_is_nmi); end
        n_cmp++; if (pending !== 8'h02) begin n_bad++; $display("FAIL nmi_pend_kept: got %h want 02", pending); end
        tick();
        pulse_eoi();
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL nmi_int_resume: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd1) begin n_bad++; $display("FAIL nmi_after_vec: got %0d want 1", irq_vec); end
        n_cmp++; if (irq_is_nmi !== 1'b0) begin n_bad++; $display("FAIL nmi_after_isnmi: got %b want 0", irq_is_nmi); end
        tick();
        pulse_eoi();
        irq = 8'h00; nmi_src = 1'b0;
        tick();
        // Global disable: NMI still served, maskable line waits.
        gdis = 1'b1;
        irq = 8'h10; nmi_src = 1'b1;
        wait_nmi(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL gdis_nmi_wait: got %b want 1", ok); end
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL gdis_int_low: got %b want 0", INT); end
        pulse_ina();
        n_cmp++; if (irq_is_nmi !== 1'b1) begin n_bad++; $display("FAIL gdis_isnmi: got %b want 1", irq_is_nmi); end
        tick();
        pulse_eoi();
        tick(); tick(); tick(); tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL gdis_int_held: got %b want 0", INT); end
        n_cmp++; if (pending !== 8'h10) begin n_bad++; $display("FAIL gdis_pend: got %h want 10", pending); end
        n_cmp++; if (INT_Disable !== 1'b1) begin n_bad++; $display("FAIL gdis_intdis: got %b want 1", INT_Disable); end
        gdis = 1'b0;
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL gdis_release_wait: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd4) begin n_bad++; $display("FAIL gdis_vec: got %0d want 4", irq_vec); end
        tick();
        pulse_eoi();
        irq = 8'h00; nmi_src = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_service();
        bit ok;
        mask_we = 1'b1; mask_wdata = 8'h80;
        tick();
        mask_we = 1'b0;
        irq = 8'h41;
        wait_int(10, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rsv_wait: got %b want 1", ok); end
        pulse_ina();
        n_cmp++; if (irq_vec !== 3'd0) begin n_bad++; $display("FAIL rsv_vec: got %0d want 0", irq_vec); end
        tick();
        n_cmp++; if (INT_Disable !== 1'b1) begin n_bad++; $display("FAIL rsv_in_service: got %b want 1", INT_Disable); end
        #2;
        rst_n = 1'b0;
        irq = 8'h00;
        #1;
        n_cmp++; if (INT_Disable !== 1'b0) begin n_bad++; $display("FAIL rsv_async_intdis: got %b want 0", INT_Disable); end
        n_cmp++; if (INT !== 1'b0 || NMI !== 1'b0) begin n_bad++; $display("FAIL rsv_async_req: got %b%b want 00", INT, NMI); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rsv_async_pend: got %h want 00", pending); end
        n_cmp++; if (mask !== 8'h00) begin n_bad++; $display("FAIL rsv_async_mask: got %h want 00", mask); end
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        n_cmp++; if (INT !== 1'b0) begin n_bad++; $display("FAIL rsv_post_int: got %b want 0", INT); end
        n_cmp++; if (NMI !== 1'b0) begin n_bad++; $display("FAIL rsv_post_nmi: got %b want 0", NMI); end
        n_cmp++; if (pending !== 8'h00) begin n_bad++; $display("FAIL rsv_post_pend: got %h want 00", pending); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_mask();
        test_nmi();
        test_reset_in_service();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
